// File: rtl/psm_pkg.sv
// Shared definitions for the PSM arbiter: FSM state encoding and nominal PSM phase timing.
package psm_pkg;

  typedef enum logic [2:0] {
    PSM_IDLE  = 3'd0,
    PSM_START = 3'd1,
    PSM_RUN   = 3'd2,
    PSM_DONE  = 3'd3,
    PSM_ABORT = 3'd4
  } psm_state_e;

  localparam int OP1_CYCLES      = 2;
  localparam int OP2_CYCLES      = 5;
  localparam int OP3_CYCLES      = 3;
  localparam int NOMINAL_LATENCY = 13;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request strictly above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               valid
);

  logic [IDW-1:0] cand_s;
  logic           hit_s;

  // Walk the requesters from pointer+1 around to the pointer itself; keep the first hit.
  always_comb begin
    grant  = '0;
    idx    = '0;
    valid  = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDW'((int'(ptr) + k) % NUM_REQ);
      hit_s  = req[cand_s] & ~valid;
      idx    = hit_s ? cand_s : idx;
      valid  = valid | hit_s;
    end
    grant[idx] = valid;
  end

endmodule

// File: rtl/psm_arbiter.sv
// Round-robin front end sharing one PSM sequencer between NUM_REQ requesters,
// with per-phase result capture and a watchdog that aborts stalled transactions.
module psm_arbiter
  import psm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*WIDTH-1:0] Din1_bus,
  input  logic [NUM_REQ*WIDTH-1:0] Din2_bus,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [NUM_REQ-1:0]       Done,
  output logic                     Err,
  output logic [WIDTH-1:0]         Res_or,
  output logic [WIDTH-1:0]         Res_xor,
  output logic [WIDTH-1:0]         Res_op3,
  output logic                     Busy,
  output logic                     Psm_start,
  output logic [WIDTH-1:0]         Psm_din1,
  output logic [WIDTH-1:0]         Psm_din2,
  input  logic                     Psm_ready,
  input  logic                     Psm_op1,
  input  logic                     Psm_op2,
  input  logic                     Psm_op3,
  input  logic [WIDTH-1:0]         Psm_dout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] ST_IDLE  = PSM_IDLE;
  localparam logic [2:0] ST_START = PSM_START;
  localparam logic [2:0] ST_RUN   = PSM_RUN;
  localparam logic [2:0] ST_DONE  = PSM_DONE;
  localparam logic [2:0] ST_ABORT = PSM_ABORT;

  logic [2:0]         state_r, next_state_s;
  logic [IDW-1:0]     ptr_r, id_r, win_idx_s;
  logic [NUM_REQ-1:0] win_onehot_s, grant_r, done_r;
  logic               win_valid_s, arb_s, expire_s;
  logic               err_r, busy_r, start_r, seen_op3_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   a_r, b_r, res_or_r, res_xor_r, res_op3_r;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req   (Req),
    .ptr   (ptr_r),
    .grant (win_onehot_s),
    .idx   (win_idx_s),
    .valid (win_valid_s)
  );

  assign expire_s = (cnt_r == CW'(TIMEOUT - 1));
  assign arb_s    = (state_r == ST_IDLE) && (next_state_s == ST_START);

  // Next-state decode; a stuck PSM (ready low) keeps IDLE from arbitrating.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  next_state_s = (Psm_ready && win_valid_s) ? ST_START : ST_IDLE;
      ST_START: begin
        if (Psm_op1)       next_state_s = ST_RUN;
        else if (expire_s) next_state_s = ST_ABORT;
        else               next_state_s = ST_START;
      end
      ST_RUN: begin
        if (Psm_ready && seen_op3_r) next_state_s = ST_DONE;
        else if (expire_s)           next_state_s = ST_ABORT;
        else                         next_state_s = ST_RUN;
      end
      ST_DONE:  next_state_s = ST_IDLE;
      ST_ABORT: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State, watchdog, pointer and the registered handshake outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      ptr_r      <= IDW'(NUM_REQ - 1);
      id_r       <= '0;
      seen_op3_r <= 1'b0;
      grant_r    <= '0;
      done_r     <= '0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      start_r    <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= ((next_state_s == state_r) && ((state_r == ST_START) || (state_r == ST_RUN)))
                    ? cnt_r + CW'(1) : '0;
      grant_r    <= arb_s ? win_onehot_s : '0;
      done_r     <= ((next_state_s == ST_DONE) || (next_state_s == ST_ABORT))
                    ? (NUM_REQ'(1) << id_r) : '0;
      err_r      <= (next_state_s == ST_ABORT);
      busy_r     <= (next_state_s != ST_IDLE);
      start_r    <= (next_state_s == ST_START);
      ptr_r      <= arb_s ? win_idx_s : ptr_r;
      id_r       <= arb_s ? win_idx_s : id_r;
      seen_op3_r <= arb_s ? 1'b0 : (seen_op3_r | ((state_r == ST_RUN) & Psm_op3));
    end
  end

  // Operands are frozen at arbitration; each phase result keeps its last captured value.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      a_r       <= '0;
      b_r       <= '0;
      res_or_r  <= '0;
      res_xor_r <= '0;
      res_op3_r <= '0;
    end else begin
      a_r       <= arb_s ? Din1_bus[win_idx_s*WIDTH +: WIDTH] : a_r;
      b_r       <= arb_s ? Din2_bus[win_idx_s*WIDTH +: WIDTH] : b_r;
      res_or_r  <= ((state_r == ST_RUN) && Psm_op1) ? Psm_dout : res_or_r;
      res_xor_r <= ((state_r == ST_RUN) && Psm_op2) ? Psm_dout : res_xor_r;
      res_op3_r <= ((state_r == ST_RUN) && Psm_op3) ? Psm_dout : res_op3_r;
    end
  end

  assign Grant     = grant_r;
  assign Done      = done_r;
  assign Err       = err_r;
  assign Busy      = busy_r;
  assign Psm_start = start_r;
  assign Psm_din1  = a_r;
  assign Psm_din2  = b_r;
  assign Res_or    = res_or_r;
  assign Res_xor   = res_xor_r;
  assign Res_op3   = res_op3_r;

endmodule

// File: tb/tb_psm_arbiter.sv
// Self-checking bench for psm_arbiter: behavioural PSM model, round-robin reference and scenario tasks.
module tb_psm_arbiter;
  import psm_pkg::*;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int TO  = 16;
  localparam int TOT = OP1_CYCLES + OP2_CYCLES + OP3_CYCLES;

  logic            Clock;
  logic            Reset;
  logic [NR-1:0]   Req;
  logic [NR*W-1:0] Din1_bus, Din2_bus;
  logic [NR-1:0]   Grant, Done;
  logic            Err, Busy, Psm_start;
  logic [W-1:0]    Res_or, Res_xor, Res_op3, Psm_din1, Psm_din2;
  logic            Psm_ready, Psm_op1, Psm_op2, Psm_op3;
  logic [W-1:0]    Psm_dout;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ref_ptr = NR - 1;
  logic [23:0] last_res = 24'd0;
  bit          stuck_mode = 1'b0;

  psm_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Din1_bus(Din1_bus), .Din2_bus(Din2_bus),
    .Grant(Grant), .Done(Done), .Err(Err), .Res_or(Res_or), .Res_xor(Res_xor),
    .Res_op3(Res_op3), .Busy(Busy), .Psm_start(Psm_start), .Psm_din1(Psm_din1),
    .Psm_din2(Psm_din2), .Psm_ready(Psm_ready), .Psm_op1(Psm_op1), .Psm_op2(Psm_op2),
    .Psm_op3(Psm_op3), .Psm_dout(Psm_dout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Behavioural PSM: samples Start, runs Op1/Op2/Op3, final value only on the last cycle of each phase.
  initial begin : psm_model
    int pc;
    bit st, stuck_active;
    logic [W-1:0] ma, mb, d1, d2;
    pc = 0; stuck_active = 1'b0; ma = '0; mb = '0;
    Psm_ready = 1'b1; Psm_op1 = 1'b0; Psm_op2 = 1'b0; Psm_op3 = 1'b0; Psm_dout = '0;
    forever begin
      @(negedge Clock);
      st = Psm_start; d1 = Psm_din1; d2 = Psm_din2;
      @(posedge Clock);
      #1;
      if (!Reset) begin
        pc = 0; stuck_active = 1'b0;
      end else if (stuck_active) begin
        stuck_active = stuck_mode;
      end else if (pc == 0) begin
        if (st) begin
          ma = d1; mb = d2;
          if (stuck_mode) stuck_active = 1'b1;
          else pc = 1;
        end
      end else begin
        pc = (pc == TOT) ? 0 : pc + 1;
      end
      Psm_ready = (pc == 0) && !stuck_active;
      Psm_op1   = (pc >= 1) && (pc <= OP1_CYCLES);
      Psm_op2   = (pc > OP1_CYCLES) && (pc <= OP1_CYCLES + OP2_CYCLES);
      Psm_op3   = (pc > OP1_CYCLES + OP2_CYCLES) && (pc <= TOT);
      Psm_dout  = (pc == OP1_CYCLES) ? (ma | mb) :
                  (pc == OP1_CYCLES + OP2_CYCLES) ? (ma ^ mb) :
                  (pc == TOT) ? (ma | ~mb) : W'($urandom);
    end
  end

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [23:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a | b, a ^ b, a | ~b};
  endfunction

  // Requester behaviour plus observation: drop Req on Grant unless kept, stop at the first Done.
  task automatic observe(input int budget, input logic [NR-1:0] keep, output int gc,
                         output logic [NR-1:0] g, output int dc, output logic [NR-1:0] d,
                         output logic e, output logic [23:0] res);
    gc = -1; g = '0; dc = -1; d = '0; e = 1'b0; res = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (Grant != '0 && gc < 0) begin
        gc = cyc; g = Grant; Req = Req & ~(Grant & ~keep);
      end
      if (Done != '0) begin
        dc = cyc; d = Done; e = Err; res = {Res_or, Res_xor, Res_op3};
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; Req = '0; Din1_bus = '0; Din2_bus = '0;
    repeat (3) @(negedge Clock);
    n_vec++; if ({Grant, Done, Err, Busy, Psm_start} !== 11'd0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", {Grant, Done, Err, Busy, Psm_start}); end
    n_vec++; if ({Res_or, Res_xor, Res_op3, Psm_din1, Psm_din2} !== 40'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {Res_or, Res_xor, Res_op3, Psm_din1, Psm_din2}); end
    Reset = 1'b1; ref_ptr = NR - 1;
    repeat (2) @(negedge Clock);
    n_vec++; if ({Busy, Grant, Done} !== 9'd0) begin
      n_err++; $display("FAIL idle_after_reset: got %b want 0", {Busy, Grant, Done}); end
  endtask

  task automatic test_single;
    int r, c0, gc, dc, ex;
    logic [W-1:0] a, b;
    logic [NR-1:0] g, d;
    logic e;
    logic [23:0] res;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin r = 0; a = 8'h5A; b = 8'h3C; end
      else begin r = $urandom_range(0, NR - 1); a = W'($urandom); b = W'($urandom); end
      Din1_bus[r*W +: W] = a; Din2_bus[r*W +: W] = b;
      Req = NR'(1 << r); c0 = cyc;
      observe(40, '0, gc, g, dc, d, e, res);
      ex = rr_pick(ref_ptr, NR'(1 << r)); ref_ptr = ex;
      n_vec++; if (g !== NR'(1 << ex) || gc - c0 != 1) begin
        n_err++; $display("FAIL single_grant[%0d]: got %b @%0d want %b @1", i, g, gc - c0, NR'(1 << ex)); end
      n_vec++; if (d !== NR'(1 << ex) || dc - c0 != NOMINAL_LATENCY || e !== 1'b0) begin
        n_err++; $display("FAIL single_done[%0d]: got %b err %b @%0d want %b err 0 @%0d", i, d, e, dc - c0, NR'(1 << ex), NOMINAL_LATENCY); end
      n_vec++; if (res !== exp_res(a, b)) begin
        n_err++; $display("FAIL single_results[%0d]: got %h want %h", i, res, exp_res(a, b)); end
      last_res = exp_res(a, b);
      @(negedge Clock);
    end
  endtask

  task automatic test_all_four;
    int gc, dc, ex, prev_gc;
    logic [NR-1:0] g, d;
    logic e;
    logic [23:0] res, want;
    Din1_bus = $urandom; Din2_bus = $urandom; Req = '1; prev_gc = -1;
    for (int i = 0; i < 5; i++) begin
      observe(40, '1, gc, g, dc, d, e, res);
      ex = rr_pick(ref_ptr, '1); ref_ptr = ex;
      want = exp_res(Din1_bus[ex*W +: W], Din2_bus[ex*W +: W]);
      n_vec++; if (g !== NR'(1 << ex) || d !== NR'(1 << ex) || e !== 1'b0) begin
        n_err++; $display("FAIL all4_order[%0d]: got grant %b done %b err %b want %b", i, g, d, e, NR'(1 << ex)); end
      n_vec++; if (res !== want) begin
        n_err++; $display("FAIL all4_results[%0d]: got %h want %h", i, res, want); end
      if (prev_gc >= 0) begin
        n_vec++; if (gc - prev_gc != NOMINAL_LATENCY + 1) begin
          n_err++; $display("FAIL all4_spacing[%0d]: got %0d want %0d", i, gc - prev_gc, NOMINAL_LATENCY + 1); end
      end
      prev_gc = gc; last_res = want;
      Din1_bus[ex*W +: W] = W'($urandom); Din2_bus[ex*W +: W] = W'($urandom);
    end
    Req = '0;
    @(negedge Clock);
  endtask

  task automatic test_fairness;
    int gc, dc, ex;
    logic [NR-1:0] g, d, snap;
    logic e;
    logic [23:0] res, want;
    Req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      snap = Req;
      observe(40, 4'b0100, gc, g, dc, d, e, res);
      ex = rr_pick(ref_ptr, snap); ref_ptr = ex;
      want = exp_res(Din1_bus[ex*W +: W], Din2_bus[ex*W +: W]);
      n_vec++; if (g !== NR'(1 << ex) || d !== NR'(1 << ex) || res !== want) begin
        n_err++; $display("FAIL fairness[%0d]: got grant %b done %b res %h want %b res %h", i, g, d, res, NR'(1 << ex), want); end
      last_res = want;
      if (ex == 2) Req[0] = 1'b1;
    end
    Req = '0;
    @(negedge Clock);
  endtask

  task automatic test_stuck;
    int r, r2, c0, gc, dc, ng;
    logic [NR-1:0] g, d;
    logic e;
    logic [23:0] res, want;
    stuck_mode = 1'b1;
    r = $urandom_range(0, NR - 1);
    Req = NR'(1 << r);
    observe(TO + 20, '0, gc, g, dc, d, e, res);
    ref_ptr = r;
    n_vec++; if (g !== NR'(1 << r) || d !== NR'(1 << r) || e !== 1'b1) begin
      n_err++; $display("FAIL stuck_abort: got grant %b done %b err %b want %b err 1", g, d, e, NR'(1 << r)); end
    n_vec++; if (dc - gc != TO) begin
      n_err++; $display("FAIL stuck_latency: got %0d want %0d", dc - gc, TO); end
    n_vec++; if (res !== last_res) begin
      n_err++; $display("FAIL stuck_hold_results: got %h want %h", res, last_res); end
    r2 = (r + 1) % NR; Req = NR'(1 << r2); ng = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Grant != '0 || Busy) ng++;
    end
    n_vec++; if (ng != 0) begin
      n_err++; $display("FAIL stuck_no_restart: got %0d busy/grant cycles want 0", ng); end
    stuck_mode = 1'b0; c0 = cyc;
    observe(40, '0, gc, g, dc, d, e, res);
    ref_ptr = r2;
    want = exp_res(Din1_bus[r2*W +: W], Din2_bus[r2*W +: W]);
    n_vec++; if (g !== NR'(1 << r2) || d !== NR'(1 << r2) || e !== 1'b0 || res !== want) begin
      n_err++; $display("FAIL stuck_recover: got %b/%b err %b res %h want %b res %h", g, d, e, res, NR'(1 << r2), want); end
    last_res = want;
    @(negedge Clock);
  endtask

  task automatic test_reset_mid;
    int gc, dc, nd, ex;
    logic [NR-1:0] g, d, rq;
    logic e;
    logic [23:0] res, want;
    Din1_bus = $urandom; Din2_bus = $urandom; Req = 4'b0010;
    repeat (6) begin
      @(negedge Clock);
      if (Grant != '0) Req = '0;
    end
    #2 Reset = 1'b0;
    #1;
    n_vec++; if ({Grant, Done, Err, Busy, Psm_start, Res_or, Res_xor, Res_op3, Psm_din1, Psm_din2} !== 51'd0) begin
      n_err++; $display("FAIL reset_mid_async: got %h want 0", {Grant, Done, Err, Busy, Psm_start, Res_or, Res_xor, Res_op3, Psm_din1, Psm_din2}); end
    nd = 0;
    repeat (3) begin @(negedge Clock); if (Done != '0) nd++; end
    Reset = 1'b1; ref_ptr = NR - 1;
    repeat (3) begin @(negedge Clock); if (Done != '0) nd++; end
    n_vec++; if (nd != 0) begin
      n_err++; $display("FAIL reset_mid_no_done: got %0d done cycles want 0", nd); end
    rq = NR'($urandom_range(1, (1 << NR) - 1)); rq[0] = 1'b1; Req = rq;
    observe(40, '0, gc, g, dc, d, e, res);
    Req = '0;
    ex = rr_pick(ref_ptr, rq); ref_ptr = ex;
    want = exp_res(Din1_bus[ex*W +: W], Din2_bus[ex*W +: W]);
    n_vec++; if (g !== NR'(1 << ex) || d !== NR'(1 << ex) || e !== 1'b0 || res !== want) begin
      n_err++; $display("FAIL reset_mid_restart: got %b/%b err %b res %h want %b res %h", g, d, e, res, NR'(1 << ex), want); end
    last_res = want;
    @(negedge Clock);
  endtask

  task automatic test_operand_stability;
    int r, nbad;
    bit g_seen, changed, done_seen;
    logic [W-1:0] a, b;
    logic [NR-1:0] d;
    logic e;
    logic [23:0] res;
    r = $urandom_range(0, NR - 1); a = W'($urandom); b = W'($urandom);
    Din1_bus[r*W +: W] = a; Din2_bus[r*W +: W] = b; Req = NR'(1 << r);
    g_seen = 1'b0; changed = 1'b0; done_seen = 1'b0; nbad = 0; d = '0; e = 1'b0; res = '0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      @(negedge Clock);
      if (g_seen && !changed) begin
        Din1_bus[r*W +: W] = ~a; Din2_bus[r*W +: W] = ~b; changed = 1'b1;
      end
      if (Grant != '0 && !g_seen) begin g_seen = 1'b1; Req = '0; end
      if (changed && (Psm_din1 !== a || Psm_din2 !== b)) nbad++;
      if (Done != '0) begin done_seen = 1'b1; d = Done; e = Err; res = {Res_or, Res_xor, Res_op3}; end
    end
    ref_ptr = r;
    n_vec++; if (nbad != 0 || !changed) begin
      n_err++; $display("FAIL stability_din: got %0d unstable cycles (changed=%0d) want 0", nbad, changed); end
    n_vec++; if (d !== NR'(1 << r) || e !== 1'b0 || res !== exp_res(a, b)) begin
      n_err++; $display("FAIL stability_results: got %b err %b res %h want %b res %h", d, e, res, NR'(1 << r), exp_res(a, b)); end
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_stuck();
    test_reset_mid();
    test_operand_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
